// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit driving a single-outstanding req/ack data bus.
// Define MEM_LSU_TIMEOUT_EN to add a bus-wait timeout that reports a bus error on align_err.
module mem_lsu #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OP_W-1:0]       ex_aluop,
    input  logic [ADDR_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_reg2,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  flush,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [3:0]            bus_sel,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_ack,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  stall_req,
    output logic                  align_err
);

    localparam logic [OP_W-1:0] OP_LB  = OP_W'(8'hE0);
    localparam logic [OP_W-1:0] OP_LH  = OP_W'(8'hE1);
    localparam logic [OP_W-1:0] OP_LW  = OP_W'(8'hE3);
    localparam logic [OP_W-1:0] OP_LBU = OP_W'(8'hE4);
    localparam logic [OP_W-1:0] OP_LHU = OP_W'(8'hE5);
    localparam logic [OP_W-1:0] OP_SB  = OP_W'(8'hE8);
    localparam logic [OP_W-1:0] OP_SH  = OP_W'(8'hE9);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(8'hEB);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_reg;
    logic                bus_req_reg;
    logic                bus_we_reg;
    logic [ADDR_W-1:0]   bus_addr_reg;
    logic [3:0]          bus_sel_reg;
    logic [DATA_W-1:0]   bus_wdata_reg;
    logic                load_reg;
    logic                signed_reg;
    logic [1:0]          size_reg;
    logic [1:0]          lane_reg;
    logic                flushed_reg;
    logic [DATA_W-1:0]   result_reg;
    logic                bus_fault;

    logic                is_mem;
    logic                is_load;
    logic                is_signed;
    logic [1:0]          size;
    logic                misaligned;
    logic                start;
    logic [3:0]          sel_next;
    logic [DATA_W-1:0]   wdata_next;
    logic [7:0]          byte_lane;
    logic [15:0]         half_lane;
    logic [DATA_W-1:0]   load_val;

`ifdef MEM_LSU_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0]          wait_cnt_reg;
    logic                bus_err_reg;
    assign bus_fault = bus_err_reg;
`else
    assign bus_fault = 1'b0;
`endif

    always_comb begin
        is_mem    = 1'b1;
        is_load   = 1'b1;
        is_signed = 1'b0;
        size      = SZ_WORD;
        case (ex_aluop)
            OP_LB:   begin size = SZ_BYTE; is_signed = 1'b1; end
            OP_LH:   begin size = SZ_HALF; is_signed = 1'b1; end
            OP_LW:   size = SZ_WORD;
            OP_LBU:  size = SZ_BYTE;
            OP_LHU:  size = SZ_HALF;
            OP_SB:   begin size = SZ_BYTE; is_load = 1'b0; end
            OP_SH:   begin size = SZ_HALF; is_load = 1'b0; end
            OP_SW:   is_load = 1'b0;
            default: begin is_mem = 1'b0; is_load = 1'b0; end
        endcase
    end

    assign misaligned = is_mem &&
                        (((size == SZ_HALF) && ex_mem_addr[0]) ||
                         ((size == SZ_WORD) && (ex_mem_addr[1:0] != 2'b00)));
    assign start = (state_reg == IDLE) && is_mem && !misaligned && !flush;

    // Lane 0 is the most significant byte of the bus word.
    always_comb begin
        case (size)
            SZ_BYTE: sel_next = 4'b1000 >> ex_mem_addr[1:0];
            SZ_HALF: sel_next = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
            default: sel_next = 4'b1111;
        endcase
    end

    // Store data: bytes copied to every lane, halfwords to both halves.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_store_lane
            localparam int HB = (gi % 2) * 8;
            assign wdata_next[gi*8 +: 8] = (size == SZ_BYTE) ? ex_reg2[7:0] :
                                           (size == SZ_HALF) ? ex_reg2[HB +: 8] :
                                                               ex_reg2[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        case (lane_reg)
            2'd0:    byte_lane = bus_rdata[31:24];
            2'd1:    byte_lane = bus_rdata[23:16];
            2'd2:    byte_lane = bus_rdata[15:8];
            default: byte_lane = bus_rdata[7:0];
        endcase
        half_lane = lane_reg[1] ? bus_rdata[15:0] : bus_rdata[31:16];
        case (size_reg)
            SZ_BYTE: load_val = {{(DATA_W-8){signed_reg & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_val = {{(DATA_W-16){signed_reg & half_lane[15]}}, half_lane};
            default: load_val = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_sel_reg   <= 4'b0000;
            bus_wdata_reg <= '0;
            load_reg      <= 1'b0;
            signed_reg    <= 1'b0;
            size_reg      <= SZ_WORD;
            lane_reg      <= 2'b00;
            flushed_reg   <= 1'b0;
            result_reg    <= '0;
`ifdef MEM_LSU_TIMEOUT_EN
            wait_cnt_reg  <= 8'd0;
            bus_err_reg   <= 1'b0;
`endif
        end else begin
`ifdef MEM_LSU_TIMEOUT_EN
            bus_err_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        bus_req_reg   <= 1'b1;
                        bus_we_reg    <= !is_load;
                        bus_addr_reg  <= {ex_mem_addr[ADDR_W-1:2], 2'b00};
                        bus_sel_reg   <= sel_next;
                        bus_wdata_reg <= wdata_next;
                        load_reg      <= is_load;
                        signed_reg    <= is_signed;
                        size_reg      <= size;
                        lane_reg      <= ex_mem_addr[1:0];
                        flushed_reg   <= 1'b0;
`ifdef MEM_LSU_TIMEOUT_EN
                        wait_cnt_reg  <= 8'd0;
`endif
                        state_reg     <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        flushed_reg <= 1'b1;
                    end
                    // A flushed access still has to finish on the bus; its data is dropped.
                    if (bus_ack) begin
                        bus_req_reg <= 1'b0;
                        result_reg  <= load_reg ? load_val : '0;
                        state_reg   <= (flushed_reg || flush) ? IDLE : DONE;
                    end
`ifdef MEM_LSU_TIMEOUT_EN
                    else if (wait_cnt_reg == WAIT_LAST) begin
                        bus_req_reg <= 1'b0;
                        result_reg  <= '0;
                        bus_err_reg <= 1'b1;
                        state_reg   <= (flushed_reg || flush) ? IDLE : DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
`endif
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_sel   = bus_sel_reg;
    assign bus_wdata = bus_wdata_reg;

    always_comb begin
        mem_wd    = '0;
        mem_wreg  = 1'b0;
        mem_wdata = '0;
        stall_req = 1'b0;
        align_err = 1'b0;
        if (!rst) begin
            mem_wd = ex_wd;
            case (state_reg)
                IDLE: begin
                    mem_wdata = ex_wdata;
                    if (is_mem) begin
                        align_err = misaligned;
                        stall_req = !misaligned && !flush;
                    end else begin
                        mem_wreg = ex_wreg && !flush;
                    end
                end
                BUSY: begin
                    mem_wdata = result_reg;
                    stall_req = 1'b1;
                end
                DONE: begin
                    mem_wdata = result_reg;
                    mem_wreg  = ex_wreg && load_reg && !flush && !bus_fault;
                end
                default: begin
                    mem_wdata = '0;
                end
            endcase
            align_err = align_err || bus_fault;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized self-checking bench for mem_lsu against a behavioural access model.
// Covers the MEM_LSU_TIMEOUT_EN build when that macro is defined.
module tb_mem_lsu;

    localparam logic [7:0] LB  = 8'hE0;
    localparam logic [7:0] LH  = 8'hE1;
    localparam logic [7:0] LW  = 8'hE3;
    localparam logic [7:0] LBU = 8'hE4;
    localparam logic [7:0] LHU = 8'hE5;
    localparam logic [7:0] SB  = 8'hE8;
    localparam logic [7:0] SH  = 8'hE9;
    localparam logic [7:0] SW  = 8'hEB;
    localparam logic [7:0] NOP = 8'h21;

    logic        clk;
    logic        rst;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        flush;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stall_req;
    logic        align_err;

    int checks = 0;
    int errors = 0;

    mem_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .flush(flush),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .stall_req(stall_req), .align_err(align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic bit is_mem_op(input logic [7:0] op);
        return op inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
    endfunction

    function automatic bit is_store_op(input logic [7:0] op);
        return op inside {SB, SH, SW};
    endfunction

    function automatic int op_bytes(input logic [7:0] op);
        if (op inside {LB, LBU, SB}) return 1;
        if (op inside {LH, LHU, SH}) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_sel(input logic [7:0] op, input logic [31:0] addr);
        int pos;
        pos = int'(addr[1:0]);
        case (op_bytes(op))
            1:       return 4'(1 << (3 - pos));
            2:       return (pos < 2) ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [31:0] d);
        case (op_bytes(op))
            1:       return {4{d[7:0]}};
            2:       return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int unsigned v;
        int pos;
        pos = int'(addr[1:0]);
        case (op_bytes(op))
            1: begin
                v = (rdata >> (8 * (3 - pos))) & 32'hFF;
                if (op == LB && v >= 128) v = v + 32'hFFFFFF00;
            end
            2: begin
                v = (rdata >> (16 * (1 - pos / 2))) & 32'hFFFF;
                if (op == LH && v >= 32768) v = v + 32'hFFFF0000;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] rand_aligned(input logic [7:0] op);
        logic [31:0] a;
        a = $urandom;
        if (op_bytes(op) == 2) a[0] = 1'b0;
        if (op_bytes(op) == 4) a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic set_nop();
        ex_aluop = NOP; ex_wreg = 1'b0; ex_wdata = 32'h0; ex_wd = 5'd0; flush = 1'b0;
    endtask

    // One complete aligned access; ack arrives in BUSY cycle ack_cycle (1-based).
    task automatic do_access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] d,
                             input logic [31:0] rdata, input int ack_cycle, input logic wreg);
        int stalls;
        bit st;
        logic [4:0] wd;
        stalls = 0;
        st = is_store_op(op);
        wd = 5'($urandom);
        ex_aluop = op; ex_mem_addr = addr; ex_reg2 = d; ex_wd = wd; ex_wreg = wreg;
        ex_wdata = $urandom; flush = 1'b0;
        #1;
        if (stall_req === 1'b1) stalls++;
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL acc_align: got %b want 0", align_err); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL acc_req_idle: got %b want 0", bus_req); end
        checks++; if (mem_wreg !== 1'b0) begin errors++; $display("FAIL acc_wreg_idle: got %b want 0", mem_wreg); end
        @(negedge clk);
        checks++; if (bus_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL acc_addr: got %h want %h", bus_addr, {addr[31:2], 2'b00}); end
        checks++; if (bus_sel !== model_sel(op, addr)) begin errors++; $display("FAIL acc_sel: got %b want %b", bus_sel, model_sel(op, addr)); end
        checks++; if (bus_we !== st) begin errors++; $display("FAIL acc_we: got %b want %b", bus_we, st); end
        if (st) begin
            checks++; if (bus_wdata !== model_wdata(op, d)) begin errors++; $display("FAIL acc_wdata: got %h want %h", bus_wdata, model_wdata(op, d)); end
        end
        for (int k = 1; k <= ack_cycle; k++) begin
            if (k > 1) @(negedge clk);
            bus_ack = (k == ack_cycle);
            bus_rdata = (k == ack_cycle) ? rdata : $urandom;
            #1;
            if (stall_req === 1'b1) stalls++;
            checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL acc_req_busy: got %b want 1 (cycle %0d)", bus_req, k); end
        end
        @(negedge clk);
        bus_ack = 1'b0;
        bus_rdata = $urandom;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL acc_stall_done: got %b want 0", stall_req); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL acc_req_done: got %b want 0", bus_req); end
        checks++; if (mem_wreg !== (wreg && !st)) begin errors++; $display("FAIL acc_wreg_done: got %b want %b", mem_wreg, wreg && !st); end
        checks++; if (mem_wd !== wd) begin errors++; $display("FAIL acc_wd_done: got %0d want %0d", mem_wd, wd); end
        if (!st) begin
            checks++; if (mem_wdata !== model_load(op, addr, rdata)) begin errors++; $display("FAIL acc_load: got %h want %h", mem_wdata, model_load(op, addr, rdata)); end
        end
        checks++; if (stalls != ack_cycle + 1) begin errors++; $display("FAIL acc_stall_cycles: got %0d want %0d", stalls, ack_cycle + 1); end
        $display("access op=%h addr=%h data=%h rdata=%h ack_cycle=%0d mem_wdata=%h stalls=%0d",
                 op, addr, d, rdata, ack_cycle, mem_wdata, stalls);
        @(negedge clk);
        set_nop();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        ex_aluop = NOP; ex_wreg = 1'b1; ex_wdata = 32'h1234; ex_wd = 5'd3; flush = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        checks++; if (mem_wreg !== 1'b0) begin errors++; $display("FAIL rst_wreg: got %b want 0", mem_wreg); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        checks++; if (mem_wd !== 5'd0) begin errors++; $display("FAIL rst_wd: got %0d want 0", mem_wd); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus_req); end
        checks++; if (bus_sel !== 4'b0) begin errors++; $display("FAIL rst_sel: got %b want 0", bus_sel); end
        ex_aluop = LW; ex_mem_addr = 32'h101;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall_req); end
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL rst_align: got %b want 0", align_err); end
        $display("reset checked");
        @(negedge clk);
        rst = 1'b0;
        set_nop();
    endtask

    task automatic test_passthrough();
        ex_aluop = NOP; ex_wdata = 32'h1234; ex_wd = 5'd3; ex_wreg = 1'b1; flush = 1'b0;
        #1;
        checks++; if (mem_wdata !== 32'h1234) begin errors++; $display("FAIL pt_wdata: got %h want 00001234", mem_wdata); end
        checks++; if (mem_wd !== 5'd3) begin errors++; $display("FAIL pt_wd: got %0d want 3", mem_wd); end
        checks++; if (mem_wreg !== 1'b1) begin errors++; $display("FAIL pt_wreg: got %b want 1", mem_wreg); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL pt_stall: got %b want 0", stall_req); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL pt_req: got %b want 0", bus_req); end
        $display("passthrough op=21 wdata=%h wd=%0d wreg=%b", mem_wdata, mem_wd, mem_wreg);
        for (int i = 0; i < 12; i++) begin
            logic [7:0] op;
            @(negedge clk);
            do op = 8'($urandom); while (is_mem_op(op));
            ex_aluop = op; ex_wdata = $urandom; ex_wd = 5'($urandom); ex_wreg = 1'($urandom);
            flush = ($urandom_range(0, 3) == 0);
            bus_ack = 1'($urandom);
            bus_rdata = $urandom;
            #1;
            checks++; if (mem_wdata !== ex_wdata) begin errors++; $display("FAIL pt_rand_wdata: got %h want %h", mem_wdata, ex_wdata); end
            checks++; if (mem_wd !== ex_wd) begin errors++; $display("FAIL pt_rand_wd: got %0d want %0d", mem_wd, ex_wd); end
            checks++; if (mem_wreg !== (ex_wreg && !flush)) begin errors++; $display("FAIL pt_rand_wreg: got %b want %b", mem_wreg, ex_wreg && !flush); end
            checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL pt_rand_stall: got %b want 0", stall_req); end
            checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL pt_rand_req: got %b want 0 (ack ignored in IDLE)", bus_req); end
            $display("passthrough op=%h wdata=%h flush=%b ack=%b", op, ex_wdata, flush, bus_ack);
        end
        @(negedge clk);
        bus_ack = 1'b0;
        set_nop();
    endtask

    task automatic test_loads();
        logic [7:0] ops [5];
        ops = '{LB, LH, LW, LBU, LHU};
        do_access(LB, 32'h102, 32'h0, 32'h11228344, 2, 1'b1);
        do_access(LBU, 32'h102, 32'h0, 32'h11228344, 2, 1'b1);
        for (int i = 0; i < 12; i++) begin
            logic [7:0] op;
            op = ops[$urandom_range(0, 4)];
            do_access(op, rand_aligned(op), 32'h0, $urandom, $urandom_range(1, 3), 1'($urandom));
        end
    endtask

    task automatic test_stores();
        logic [7:0] ops [3];
        ops = '{SB, SH, SW};
        do_access(SH, 32'h206, 32'hAAAABEEF, 32'h0, 1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] op;
            op = ops[$urandom_range(0, 2)];
            do_access(op, rand_aligned(op), $urandom, $urandom, $urandom_range(1, 3), 1'b1);
        end
    endtask

    task automatic test_misaligned();
        logic [7:0]  ops [5];
        logic [31:0] addrs [5];
        ops = '{LW, LH, SW, SH, LHU};
        addrs = '{32'h102, 32'h101, 32'h203, 32'h3, 32'h7};
        for (int i = 0; i < 5; i++) begin
            ex_aluop = ops[i]; ex_mem_addr = addrs[i]; ex_wreg = 1'b1; ex_wdata = $urandom; flush = 1'b0;
            #1;
            checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL mis_align: got %b want 1", align_err); end
            checks++; if (mem_wreg !== 1'b0) begin errors++; $display("FAIL mis_wreg: got %b want 0", mem_wreg); end
            checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b want 0", stall_req); end
            @(negedge clk);
            #1;
            checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b want 0", bus_req); end
            $display("misaligned op=%h addr=%h align_err=%b", ops[i], addrs[i], align_err);
            @(negedge clk);
        end
        ex_aluop = LW; ex_mem_addr = 32'h100; ex_wreg = 1'b1; flush = 1'b1;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b want 0", stall_req); end
        checks++; if (mem_wreg !== 1'b0) begin errors++; $display("FAIL flush_idle_wreg: got %b want 0", mem_wreg); end
        @(negedge clk);
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL flush_idle_req: got %b want 0", bus_req); end
        $display("flush in idle op=LW addr=100 bus_req=%b", bus_req);
        @(negedge clk);
        set_nop();
    endtask

    task automatic test_flush_busy();
        ex_aluop = LW; ex_mem_addr = 32'h300; ex_wreg = 1'b1; ex_wd = 5'd7; flush = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL fb_stall_1: got %b want 1", stall_req); end
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            flush = 1'b0;
            bus_ack = (k == 4);
            bus_rdata = 32'hCAFEF00D;
            #1;
            checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL fb_stall: got %b want 1 (cycle %0d)", stall_req, k); end
            checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL fb_req: got %b want 1 (cycle %0d)", bus_req, k); end
        end
        @(negedge clk);
        bus_ack = 1'b0;
        ex_aluop = NOP; ex_wreg = 1'b0; ex_wdata = 32'h0BAD5EED;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL fb_stall_after: got %b want 0", stall_req); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL fb_req_after: got %b want 0", bus_req); end
        checks++; if (mem_wreg !== 1'b0) begin errors++; $display("FAIL fb_wreg_after: got %b want 0", mem_wreg); end
        checks++; if (mem_wdata !== 32'h0BAD5EED) begin errors++; $display("FAIL fb_no_done: got %h want 0bad5eed", mem_wdata); end
        $display("flush in busy op=LW addr=300 discarded mem_wdata=%h", mem_wdata);
        @(negedge clk);
        set_nop();
    endtask

    task automatic test_reset_busy();
        ex_aluop = LHU; ex_mem_addr = 32'h402; ex_wreg = 1'b1; flush = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rb_req_busy: got %b want 1", bus_req); end
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rb_req: got %b want 0", bus_req); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rb_stall: got %b want 0", stall_req); end
        rst = 1'b0;
        set_nop();
        ex_wreg = 1'b1; ex_wdata = 32'h600D;
        #1;
        checks++; if (mem_wdata !== 32'h600D || stall_req !== 1'b0) begin errors++; $display("FAIL rb_idle: got wdata %h stall %b want 0000600d stall 0", mem_wdata, stall_req); end
        $display("reset in busy bus_req=%b", bus_req);
        @(negedge clk);
        set_nop();
    endtask

`ifdef MEM_LSU_TIMEOUT_EN
    task automatic test_timeout();
        ex_aluop = LW; ex_mem_addr = 32'h500; ex_wreg = 1'b1; flush = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL to_req: got %b want 1 (cycle %0d)", bus_req, k); end
            @(negedge clk);
        end
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL to_req_drop: got %b want 0", bus_req); end
        checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", align_err); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL to_wdata: got %h want 0", mem_wdata); end
        checks++; if (mem_wreg !== 1'b0) begin errors++; $display("FAIL to_wreg: got %b want 0", mem_wreg); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL to_stall: got %b want 0", stall_req); end
        @(negedge clk);
        set_nop();
        #1;
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse: got %b want 0", align_err); end
        $display("timeout op=LW addr=500 bus error reported");
        @(negedge clk);
    endtask
`else
    task automatic test_no_timeout();
        do_access(LW, 32'h500, 32'h0, 32'h89ABCDEF, 10, 1'b1);
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus_ack = 1'b0;
        bus_rdata = 32'h0;
        ex_mem_addr = 32'h0;
        ex_reg2 = 32'h0;
        set_nop();
        @(negedge clk);
        test_reset();
        test_passthrough();
        test_loads();
        test_stores();
        test_misaligned();
        test_flush_busy();
        test_reset_busy();
`ifdef MEM_LSU_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
